prog_loader: RTL and testbench

- Writer side of the Hack instruction memory: receives a program as a byte stream (from the UART receiver), packs bytes into 16-bit Hack instructions and writes them sequentially into instruction RAM.
- Verifies a length header and an XOR checksum.
- Holds the CPU in reset until a valid image is fully loaded.
- Sits between the UART RX and the instruction RAM write port; the CPU fetch side reads the same RAM.

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// Program loader: unpacks a length-prefixed, XOR-checked byte stream into 16-bit Hack words for instruction RAM.
// Latency: mem_we pulses one clock after the edge that accepts a word's low byte; done/error register on the CHK byte.
// Backpressure: none; every rx_valid byte in a receiving state is consumed, so at most one write lands every 2 cycles.
module prog_loader #(
  parameter int ADDR_W      = 15,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  localparam int                TW        = $clog2(TIMEOUT_CYC + 1);
  // Words that fit between BASE_ADDR and the top of RAM; wide enough that it never overflows.
  localparam logic [32:0]       CAP_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
  localparam logic [TW-1:0]     TLAST     = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR
  } state_t;

  state_t            state;
  logic [15:0]       len;
  logic [7:0]        hi_byte;
  logic [7:0]        chk;
  logic [ADDR_W:0]   word_idx;
  logic [TW-1:0]     tcnt;

  logic              timed_state;
  logic              last_word;
  logic              oversize;
  logic [15:0]       len_now;

  // Timeout only applies once a frame has started and before it resolves.
  assign timed_state = (state == LEN_LO) || (state == DATA_HI) ||
                       (state == DATA_LO) || (state == CHK);
  assign len_now     = {len[15:8], rx_data};
  assign oversize    = 33'(len_now) > CAP_WORDS;
  assign last_word   = (33'(word_idx) + 33'd1) == 33'(len);

  // Frame parser, write-port driver, checksum and timeout in one registered FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN_HI;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
      len       <= 16'h0000;
      hi_byte   <= 8'h00;
      chk       <= 8'h00;
      word_idx  <= '0;
      tcnt      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        // Re-arm; a byte arriving with start is dropped.
        state     <= LEN_HI;
        busy      <= 1'b0;
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_rst_n <= 1'b0;
        chk       <= 8'h00;
        word_idx  <= '0;
        tcnt      <= '0;
      end else begin
        if (timed_state) begin
          if (rx_valid) begin
            tcnt <= '0;
          end else if (tcnt == TLAST) begin
            state     <= ERR;
            error     <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        if (rx_valid) begin
          case (state)
            LEN_HI: begin
              len[15:8] <= rx_data;
              chk       <= chk ^ rx_data;
              busy      <= 1'b1;
              state     <= LEN_LO;
            end
            LEN_LO: begin
              len[7:0] <= rx_data;
              chk      <= chk ^ rx_data;
              if (oversize) begin
                state <= ERR;
                error <= 1'b1;
                busy  <= 1'b0;
              end else if (len_now == 16'h0000) begin
                state <= CHK;
              end else begin
                state <= DATA_HI;
              end
            end
            DATA_HI: begin
              hi_byte <= rx_data;
              chk     <= chk ^ rx_data;
              state   <= DATA_LO;
            end
            DATA_LO: begin
              mem_we    <= 1'b1;
              mem_wdata <= {hi_byte, rx_data};
              mem_addr  <= BASE + word_idx[ADDR_W-1:0];
              word_idx  <= word_idx + 1'b1;
              chk       <= chk ^ rx_data;
              state     <= last_word ? CHK : DATA_HI;
            end
            CHK: begin
              busy <= 1'b0;
              if (rx_data == chk) begin
                state     <= DONE;
                done      <= 1'b1;
                cpu_rst_n <= 1'b1;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Bench for prog_loader: directed frames from the bring-up scenarios plus randomized frames
// checked against a frame-level model of which words land in RAM and how the frame resolves.
module tb_prog_loader;

  localparam int AW   = 4;
  localparam int BASE = 0;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          busy, done, error, cpu_rst_n;

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every RAM write observed, and any back-to-back mem_we.
  logic [AW+15:0] wq[$];
  logic           prev_we = 1'b0;
  int             dbl = 0;
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (mem_we && prev_we) dbl++;
    prev_we = mem_we;
  end

  // Called at a falling edge; returns at the next falling edge with rx_valid dropped.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_we"},   32'(mem_we),    0);
    check({tag, "_addr"}, 32'(mem_addr),  BASE);
    check({tag, "_wd"},   32'(mem_wdata), 0);
    check({tag, "_busy"}, 32'(busy),      0);
    check({tag, "_done"}, 32'(done),      0);
    check({tag, "_err"},  32'(error),     0);
    check({tag, "_cpu"},  32'(cpu_rst_n), 0);
  endtask

  // Frame-level reference: given the frame bytes and how many were sent, decide the
  // outcome and the list of {addr,data} writes that must reach RAM.
  logic [7:0]     fr[$];
  logic [AW+15:0] ew[$];

  task automatic model(input int nsent, output bit e_done, output bit e_err);
    int n;
    logic [7:0] x;
    ew.delete();
    e_done = 1'b0;
    e_err  = 1'b0;
    if (nsent == 0) return;
    if (nsent < 2) begin e_err = 1'b1; return; end
    n = int'({fr[0], fr[1]});
    if (n > (1 << AW) - BASE) begin e_err = 1'b1; return; end
    for (int i = 0; i < n; i++)
      if (3 + 2 * i < nsent) ew.push_back({AW'(BASE + i), fr[2 + 2 * i], fr[3 + 2 * i]});
    if (nsent < 3 + 2 * n) begin e_err = 1'b1; return; end
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) x = x ^ fr[i];
    if (fr[2 + 2 * n] == x) e_done = 1'b1;
    else e_err = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nsend, mode;
    bit e_done, e_err;
    logic [7:0] x;

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; start = 1'b0;
    idle(2);
    chk_reset("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic two-word load, bytes back-to-back.
    send(8'h00);
    check("t1_busy", 32'(busy), 1);
    send(8'h02); send(8'h12); send(8'h34);
    check("t1_we0", 32'(mem_we), 1);
    check("t1_a0",  32'(mem_addr), 0);
    check("t1_d0",  32'(mem_wdata), 32'h1234);
    send(8'hAB);
    check("t1_we_one_cycle", 32'(mem_we), 0);
    send(8'hCD);
    check("t1_we1", 32'(mem_we), 1);
    check("t1_a1",  32'(mem_addr), 1);
    check("t1_d1",  32'(mem_wdata), 32'hABCD);
    send(8'h42);
    check("t1_done", 32'(done), 1);
    check("t1_cpu",  32'(cpu_rst_n), 1);
    check("t1_err",  32'(error), 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_nwr", 32'(wq.size()), 2);

    // Bad checksum: writes still happen, frame rejected.
    pulse_start();
    check("t2_done_clr", 32'(done), 0);
    check("t2_cpu_clr",  32'(cpu_rst_n), 0);
    wq.delete();
    send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h43);
    check("t2_nwr", 32'(wq.size()), 2);
    check("t2_err", 32'(error), 1);
    check("t2_done", 32'(done), 0);
    check("t2_cpu", 32'(cpu_rst_n), 0);

    // Empty frame then oversize frame.
    pulse_start(); wq.delete();
    send(8'h00); send(8'h00); send(8'h00);
    check("t3_empty_done", 32'(done), 1);
    idle(2);
    check("t3_empty_nwr", 32'(wq.size()), 0);
    pulse_start(); wq.delete();
    send(8'h00); send(8'h11);
    check("t3_over_err", 32'(error), 1);
    check("t3_over_busy", 32'(busy), 0);
    idle(3);
    check("t3_over_nwr", 32'(wq.size()), 0);

    // Timeout: error lands exactly TO cycles after the last byte.
    pulse_start(); wq.delete();
    send(8'h00); send(8'h01); send(8'h12);
    idle(TO - 1);
    check("t4_err_early", 32'(error), 0);
    check("t4_busy_early", 32'(busy), 1);
    idle(1);
    check("t4_err_at_to", 32'(error), 1);
    send(8'h99);
    idle(2);
    check("t4_err_stays", 32'(error), 1);
    check("t4_done", 32'(done), 0);
    check("t4_nwr", 32'(wq.size()), 0);

    // Restart from DONE with a colliding byte.
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    start = 1'b1; rx_data = 8'h55; rx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    check("t5_done_clr", 32'(done), 0);
    check("t5_cpu_clr", 32'(cpu_rst_n), 0);
    check("t5_byte_dropped", 32'(busy), 0);
    wq.delete();
    send(8'h00); send(8'h01); send(8'h00); send(8'h07); send(8'h06);
    check("t5_done", 32'(done), 1);
    check("t5_nwr", 32'(wq.size()), 1);
    if (wq.size() > 0) check("t5_w0", 32'(wq[0]), 32'h00007);

    // Reset between HI and LO of word 1.
    pulse_start(); wq.delete();
    send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
    #1 rst_n = 1'b0;
    #1 chk_reset("t6_async");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("t6_nwr", 32'(wq.size()), 1);
    wq.delete();
    send(8'h00); send(8'h01); send(8'h5A); send(8'h5A); send(8'h01);
    check("t6_done", 32'(done), 1);
    check("t6_nwr2", 32'(wq.size()), 1);
    if (wq.size() > 0) check("t6_w0", 32'(wq[0]), 32'h05A5A);

    // Randomized frames: good, corrupted checksum, truncated (timeout), oversize.
    for (int t = 0; t < 40; t++) begin
      fr.delete();
      mode = int'($urandom_range(0, 9));
      n = (mode == 0) ? int'($urandom_range(17, 300)) : int'($urandom_range(0, 16));
      fr.push_back(8'(n >> 8));
      fr.push_back(8'(n));
      for (int i = 0; i < ((n <= 16) ? 2 * n : 4); i++) fr.push_back(8'($urandom));
      x = 8'h00;
      foreach (fr[i]) x = x ^ fr[i];
      if (mode == 1) x = x ^ 8'($urandom_range(1, 255));
      fr.push_back(x);
      nsend = fr.size();
      if (mode == 2) nsend = int'($urandom_range(1, fr.size() - 1));
      pulse_start();
      wq.delete();
      for (int i = 0; i < nsend; i++) begin
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, TO - 1)));
        send(fr[i]);
      end
      idle(TO + 2);
      model(nsend, e_done, e_err);
      check("rnd_done", 32'(done), 32'(e_done));
      check("rnd_err",  32'(error), 32'(e_err));
      check("rnd_cpu",  32'(cpu_rst_n), 32'(e_done));
      check("rnd_busy", 32'(busy), 0);
      check("rnd_nwr",  32'(wq.size()), 32'(ew.size()));
      for (int i = 0; i < wq.size() && i < ew.size(); i++)
        check("rnd_w", 32'(wq[i]), 32'(ew[i]));
    end

    check("no_b2b_we", 32'(dbl), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
